// File: rtl/seq_restoring_divider.sv
// Restoring divider, one quotient bit per cycle; optional signed mode via DIV_SIGNED_EN.
// Latency: done WIDTH+1 cycles after accept (1 for divide-by-zero); start is ignored while busy, never queued.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH:0]   rem_sh;
    logic             last;

    // The partial remainder never exceeds the divisor, so WIDTH bits of state suffice;
    // the shifted trial value needs the extra bit.
    assign rem_sh = {rem, qreg[WIDTH-1]};
    assign last   = (cnt == CW'(WIDTH));
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    always_comb begin
        mag_dvd = (signed_op && dividend[WIDTH-1]) ? WIDTH'(0) - dividend : dividend;
        mag_dvs = (signed_op && divisor[WIDTH-1])  ? WIDTH'(0) - divisor  : divisor;
        q_fix   = neg_q ? WIDTH'(0) - qreg : qreg;
        r_fix   = neg_r ? WIDTH'(0) - rem  : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op && dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        mag_dvd = dividend;
        mag_dvs = divisor;
        q_fix   = qreg;
        r_fix   = rem;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            qreg        <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        qreg        <= mag_dvd;
                        dvs         <= mag_dvs;
                        rem         <= '0;
                        cnt         <= '0;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                RUN: begin
                    if (last) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (rem_sh >= {1'b0, dvs}) begin
                            rem  <= WIDTH'(rem_sh - {1'b0, dvs});
                            qreg <= {qreg[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= rem_sh[WIDTH-1:0];
                            qreg <= {qreg[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
